// File: rtl/dir_rom_arbiter.sv
// Round-robin arbiter that shares one combinational direction ROM among lanes.
// Pipeline: S1 holds the ROM address, S2 registers the ROM data plus the lane ID.
module dir_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 5,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_a,
  input  logic [DATA_W-1:0]         rom_spo,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  logic [ADDR_W-1:0] r_rom_a;
  logic              r_s1_valid;
  logic [ID_W-1:0]   r_s1_id;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [ID_W-1:0]   r_rsp_id;
  logic [ID_W-1:0]   r_last_gnt;

  logic              w_out_free;
  logic              w_s1_free;
  logic              w_found;
  logic [ID_W-1:0]   w_gnt;
  logic              w_accept;
  logic [ADDR_W-1:0] w_gnt_addr;

  assign w_out_free = !r_rsp_valid || rsp_ready;
  assign w_s1_free  = !r_s1_valid || w_out_free;

  // Search from last_gnt+1 upward; modulo keeps IDs below NUM_REQ.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_gnt   = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_last_gnt) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = ID_W'(idx);
      end
    end
  end

  assign w_accept   = w_found && w_s1_free && !rst;
  assign w_gnt_addr = req_addr[w_gnt*ADDR_W +: ADDR_W];

  always_comb begin
    req_ready = '0;
    if (w_accept)
      req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_a     <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_last_gnt  <= ID_W'(NUM_REQ - 1);
    end else begin
      if (w_accept) begin
        r_rom_a    <= w_gnt_addr;
        r_s1_id    <= w_gnt;
        r_s1_valid <= 1'b1;
        r_last_gnt <= w_gnt;
      end else if (w_out_free) begin
        r_s1_valid <= 1'b0;
      end

      if (r_s1_valid && w_out_free) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= rom_spo;
        r_rsp_id    <= r_s1_id;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rom_a     = r_rom_a;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_s1_valid || r_rsp_valid;

endmodule

// File: tb/tb_dir_rom_arbiter.sv
// Directed bench for dir_rom_arbiter: vector table plus corner-case sequences.
// A small direction ROM model is attached to rom_a/rom_spo.
module tb_dir_rom_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_ready;
  logic [7:0]  rom_a;
  logic [4:0]  rom_spo;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  dir_rom_arbiter #(
    .NUM_REQ(4), .ADDR_W(8), .DATA_W(5), .ID_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rom_a(rom_a), .rom_spo(rom_spo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] rom(input logic [7:0] a);
    case (a)
      8'h00: rom = 5'h1f;
      8'h10: rom = 5'h00;
      8'hF0: rom = 5'h0b;
      8'hFF: rom = 5'h01;
      8'h20: rom = 5'h01;
      8'h21: rom = 5'h00;
      8'h22: rom = 5'h1f;
      8'h23: rom = 5'h1f;
      default: rom = a[4:0] ^ a[7:3];
    endcase
  endfunction

  always_comb rom_spo = rom(rom_a);

  typedef struct {
    logic        do_rst;
    logic [3:0]  valid;
    logic [31:0] addr;
    logic        rr;
    logic [3:0]  ready;
    logic        rv;
    logic [4:0]  data;
    logic [1:0]  id;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [31:0] a,
                              logic rr, logic [3:0] rd, logic rv,
                              logic [4:0] d, logic [1:0] id, logic b);
    vec_t t;
    t.do_rst = r; t.valid = v; t.addr = a; t.rr = rr;
    t.ready = rd; t.rv = rv; t.data = d; t.id = id; t.busy = b;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  localparam logic [31:0] A = 32'h23222120;
  localparam logic [31:0] B = 32'h00F01000;
  localparam logic [31:0] C = 32'h230000FF;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    rsp_ready = 1'b0;
    #2;
    chk("reset rom_a", 32'(rom_a), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_data", 32'(rsp_data), 0);
    chk("reset rsp_id", 32'(rsp_id), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset req_ready", 32'(req_ready), 0);

    // single lane back-to-back
    vq.push_back(mk(1, 4'h1, 32'h00, 1, 4'h1, 0, 5'h00, 0, 0));
    vq.push_back(mk(0, 4'h1, 32'h10, 1, 4'h1, 0, 5'h00, 0, 1));
    vq.push_back(mk(0, 4'h1, 32'hF0, 1, 4'h1, 1, 5'h1f, 0, 1));
    vq.push_back(mk(0, 4'h1, 32'hFF, 1, 4'h1, 1, 5'h00, 0, 1));
    vq.push_back(mk(0, 4'h0, 32'hFF, 1, 4'h0, 1, 5'h0b, 0, 1));
    vq.push_back(mk(0, 4'h0, 32'hFF, 1, 4'h0, 1, 5'h01, 0, 1));
    vq.push_back(mk(0, 4'h0, 32'hFF, 1, 4'h0, 0, 5'h00, 0, 0));
    // all lanes valid: rotation
    vq.push_back(mk(1, 4'hF, A, 1, 4'h1, 0, 5'h00, 0, 0));
    vq.push_back(mk(0, 4'hF, A, 1, 4'h2, 0, 5'h00, 0, 1));
    vq.push_back(mk(0, 4'hF, A, 1, 4'h4, 1, 5'h01, 0, 1));
    vq.push_back(mk(0, 4'hF, A, 1, 4'h8, 1, 5'h00, 1, 1));
    vq.push_back(mk(0, 4'hF, A, 1, 4'h1, 1, 5'h1f, 2, 1));
    vq.push_back(mk(0, 4'hF, A, 1, 4'h2, 1, 5'h1f, 3, 1));
    vq.push_back(mk(0, 4'h0, A, 1, 4'h0, 1, 5'h01, 0, 1));
    vq.push_back(mk(0, 4'h0, A, 1, 4'h0, 1, 5'h00, 1, 1));
    vq.push_back(mk(0, 4'h0, A, 1, 4'h0, 0, 5'h00, 0, 0));
    // backpressure, lanes 1 and 2 (lane drop at row 4)
    vq.push_back(mk(1, 4'h6, B, 0, 4'h2, 0, 5'h00, 0, 0));
    vq.push_back(mk(0, 4'h6, B, 0, 4'h4, 0, 5'h00, 0, 1));
    vq.push_back(mk(0, 4'h6, B, 0, 4'h0, 1, 5'h00, 1, 1));
    vq.push_back(mk(0, 4'h0, B, 0, 4'h0, 1, 5'h00, 1, 1));
    vq.push_back(mk(0, 4'h6, B, 0, 4'h0, 1, 5'h00, 1, 1));
    vq.push_back(mk(0, 4'h6, B, 1, 4'h2, 1, 5'h00, 1, 1));
    vq.push_back(mk(0, 4'h6, B, 1, 4'h4, 1, 5'h0b, 2, 1));
    vq.push_back(mk(0, 4'h0, B, 1, 4'h0, 1, 5'h00, 1, 1));
    vq.push_back(mk(0, 4'h0, B, 1, 4'h0, 1, 5'h0b, 2, 1));
    vq.push_back(mk(0, 4'h0, B, 1, 4'h0, 0, 5'h00, 0, 0));
    // wrap and skip
    vq.push_back(mk(1, 4'h8, C, 1, 4'h8, 0, 5'h00, 0, 0));
    vq.push_back(mk(0, 4'h5, C, 1, 4'h1, 0, 5'h00, 0, 1));
    vq.push_back(mk(0, 4'h5, C, 1, 4'h4, 1, 5'h1f, 3, 1));
    vq.push_back(mk(0, 4'h0, C, 1, 4'h0, 1, 5'h01, 0, 1));
    vq.push_back(mk(0, 4'h0, C, 1, 4'h0, 1, 5'h1f, 2, 1));
    vq.push_back(mk(0, 4'h0, C, 1, 4'h0, 0, 5'h00, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].do_rst) do_reset();
      req_valid = vq[i].valid;
      req_addr  = vq[i].addr;
      rsp_ready = vq[i].rr;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vq[i].ready));
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vq[i].rv));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].busy));
      if (vq[i].rv) begin
        chk($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(vq[i].data));
        chk($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vq[i].id));
      end
      step();
    end

    // reset with S1 and S2 occupied
    do_reset();
    req_valid = 4'h3;
    req_addr  = 32'h0000F010;
    rsp_ready = 1'b0;
    step();
    step();
    #1;
    chk("full busy", 32'(busy), 1);
    chk("full req_ready", 32'(req_ready), 0);
    rst = 1'b1;
    #1;
    chk("async rsp_valid", 32'(rsp_valid), 0);
    chk("async req_ready", 32'(req_ready), 0);
    chk("async busy", 32'(busy), 0);
    chk("async rom_a", 32'(rom_a), 0);
    step();
    rst = 1'b0;
    #1;
    chk("post rst grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    chk("post rst s1 only", 32'(rsp_valid), 0);
    step();
    chk("post rst rsp_valid", 32'(rsp_valid), 1);
    chk("post rst rsp_data", 32'(rsp_data), 32'h00);
    chk("post rst rsp_id", 32'(rsp_id), 0);
    step();
    chk("no stale rsp", 32'(rsp_valid), 0);

    // idle: rom_a keeps the last accepted address
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("idle%0d rsp_valid", c), 32'(rsp_valid), 0);
      chk($sformatf("idle%0d busy", c), 32'(busy), 0);
      chk($sformatf("idle%0d rom_a", c), 32'(rom_a), 32'h10);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dir_rom_arbiter.md
Name: dir_rom_arbiter

Overview:
- Shares one combinational gradient-direction ROM (8-bit address in, 5-bit direction code out) among NUM_REQ orientation-assignment lanes of the SIFT descriptor pipeline.
- Each lane has a valid/ready request port.
- A round-robin arbiter grants one lane per cycle and drives the ROM address from a register.
- The ROM result is registered and returned on a shared response port, tagged with the requester ID and subject to downstream backpressure.

Parameters:
NUM_REQ, 4, number of requesting lanes (2..8)
ADDR_W, 8, ROM address width, {dy[3:0], dx[3:0]}
DATA_W, 5, ROM data width (direction code)
ID_W, 2, requester ID width, equal to clog2(NUM_REQ)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-lane request valid
req_addr  in  NUM_REQ*ADDR_W  per-lane address; lane i occupies bits [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  per-lane accept; at most one bit high
rom_a  out  ADDR_W  registered address to the ROM
rom_spo  in  DATA_W  combinational ROM data for rom_a
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accept
rsp_data  out  DATA_W  direction code
rsp_id  out  ID_W  lane that issued the request
busy  out  1  high when s1_valid or rsp_valid is set

Behaviour:
- Reset is asynchronous, active-high. On reset all of the following go to 0: rom_a, s1_valid, s1_id, rsp_valid, rsp_data, rsp_id, req_ready and busy. The round-robin pointer last_gnt resets to NUM_REQ-1, so lane 0 has first priority.
- Pipeline stages:
  - Stage S1 holds s1_valid, s1_id and rom_a.
  - Stage S2 is the output register set: rsp_valid, rsp_data, rsp_id.
- Pipeline control:
  - out_free = !rsp_valid | rsp_ready.
  - s1_free = !s1_valid | out_free.
- Arbitration (combinational):
  - When s1_free = 1, the granted lane g is the first lane with req_valid set, searching from last_gnt+1 upward modulo NUM_REQ.
  - req_ready[g] = 1 and every other req_ready bit = 0.
  - When s1_free = 0 or no lane is valid, req_ready = 0.
  - req_ready does not depend on req_valid of other lanes beyond the priority search, and it never depends on rsp_ready through a combinational path to a lane. Dependence on rsp_ready via out_free is permitted and documented.
- Accept at a clock edge when req_valid[g] & req_ready[g]. On accept:
  - rom_a <= req_addr[g], s1_id <= g, s1_valid <= 1, last_gnt <= g.
- S1 without accept:
  - If out_free, s1_valid <= 0.
  - rom_a holds its last value when S1 is empty.
- S1 to S2 transfer when s1_valid & out_free:
  - rsp_data <= rom_spo, rsp_id <= s1_id, rsp_valid <= 1.
- Otherwise:
  - If rsp_ready, rsp_valid <= 0.
  - When rsp_valid & !rsp_ready, rsp_data and rsp_id hold and S1 holds.
- Latency: accept at edge N gives rsp_valid at edge N+1 with rsp_data = ROM(addr).
- Throughput: 1 lookup per cycle when rsp_ready is held high.
- Responses come out in acceptance order. There is no reordering and no dropping.
- Fairness: with all lanes valid continuously, grants rotate 0,1,2,3,0,... A lane waits at most NUM_REQ-1 accepts.
- Boundary conditions:
  - Pointer wrap: after last_gnt = NUM_REQ-1 the search starts at lane 0.
  - Simultaneous events: when S2 drains and S1 fills on the same edge, both occur and no bubble is inserted.
  - Full pipeline (S1 and S2 occupied, rsp_ready = 0): req_ready is all zeros. Releasing rsp_ready for one cycle restores one accept slot in that same cycle.
  - A requester dropping req_valid without a handshake is legal and has no effect.
  - Reset mid-operation discards in-flight S1/S2 contents and no response is issued for them.
- Width rules:
  - rsp_data is exactly DATA_W bits from rom_spo, with no arithmetic.
  - g is ID_W bits wide.
  - NUM_REQ values that are not a power of two must never produce an ID >= NUM_REQ.

Test Plan:
- Single lane, direction ROM attached: lane 0 requests addr 0x00, then 0x10, then 0xF0, then 0xFF back-to-back with rsp_ready=1 -> rsp_data 0x1f, 0x00, 0x0b, 0x01 with rsp_id=0 on four consecutive cycles, each one cycle after its accept.
- All four lanes valid continuously, lane i addr = 0x20+i -> grant order 0,1,2,3,0,1; rsp_data sequence 0x01, 0x00, 0x1f, 0x1f repeating with rsp_id 0,1,2,3.
- Backpressure: lanes 1 and 2 valid, rsp_ready=0 for 5 cycles -> exactly 2 accepts, then req_ready=0 and rsp_data/rsp_id stable. Then rsp_ready=1 -> responses for lane 1 then lane 2 with no loss and no duplication, and accepts resume the same cycle.
- Wrap and skip: last grant lane 3, only lanes 0 and 2 valid -> lane 0 granted first, then lane 2.
- Reset mid-flight: assert rst with S1 and S2 occupied -> rsp_valid, req_ready and busy go to 0 immediately (asynchronous). After release, the first grant goes to lane 0 and stale responses never appear.
- Idle: no req_valid for 10 cycles -> rsp_valid=0, busy=0, rom_a unchanged.
